// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: coefficient width, block geometry, reorder FSM states
// and the zig-zag scan table (scan index k -> raster position).
package jpeg_pkg;

  localparam int unsigned W      = 16;
  localparam int unsigned N_COEF = 64;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned LANES  = 8;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_EOS_OUT = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] ZZ_TABLE [N_COEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Raster position of the k-th coefficient in zig-zag scan order.
  function automatic logic [IDX_W-1:0] zz_pos(input logic [IDX_W-1:0] k);
    return ZZ_TABLE[k];
  endfunction

endpackage

// File: rtl/jpeg_dezigzag_rows_if.sv
// Valid/back-pressure token stream with LANES parallel lanes moving together.
interface jpeg_dezigzag_rows_if #(
  parameter int unsigned LANES = 1
);
  import jpeg_pkg::*;

  logic [LANES-1:0][W-1:0] d;
  logic [LANES-1:0]        e;
  logic [LANES-1:0]        v;
  logic [LANES-1:0]        b;

  modport master (output d, e, v, input b);
  modport slave  (input d, e, v, output b);

endinterface

// File: rtl/jpeg_zigzag_rom.sv
// Combinational zig-zag scan index to raster position lookup.
module jpeg_zigzag_rom
  import jpeg_pkg::*;
(
  input  logic [IDX_W-1:0] i_k,
  output logic [IDX_W-1:0] o_pos_c
);

  assign o_pos_c = zz_pos(i_k);

endmodule

// File: rtl/jpeg_dezigzag_rows.sv
// Collects a zig-zag ordered coefficient stream into a 64-entry block buffer
// and replays it as 8 raster rows on 8 lockstep output lanes, forwarding EOS.
module jpeg_dezigzag_rows
  import jpeg_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  jpeg_dezigzag_rows_if.slave    a,
  jpeg_dezigzag_rows_if.master   b
);

  state_t                        r_state, w_state_nxt;
  logic [IDX_W-1:0]              r_k, w_k_nxt;
  logic [ROW_W-1:0]              r_row, w_row_nxt;
  logic                          r_pend_eos, w_pend_nxt;
  logic [N_COEF-1:0]             r_written;
  logic [W-1:0]                  r_buf [N_COEF];
  logic                          r_a_b;
  logic [LANES-1:0]              r_b_v, r_b_e;
  logic [LANES-1:0][W-1:0]       r_b_d, w_row_data;
  logic                          w_a_fire, w_b_fire, w_wr_en, w_clr;
  logic [IDX_W-1:0]              w_pos;

  assign a.b[0] = r_a_b;
  assign b.v    = r_b_v;
  assign b.e    = r_b_e;
  assign b.d    = r_b_d;

  assign w_a_fire = a.v[0] & ~r_a_b;
  assign w_b_fire = (&r_b_v) & ~(|b.b);

  jpeg_zigzag_rom u_rom (
    .i_k     (r_k),
    .o_pos_c (w_pos)
  );

  // Next-state, scan/row counters and buffer write/clear strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_row_nxt   = r_row;
    w_pend_nxt  = r_pend_eos;
    w_wr_en     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_a_fire) begin
          if (a.e[0]) begin
            if (r_k == '0) begin
              w_state_nxt = ST_EOS_OUT;
            end else begin
              w_pend_nxt  = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          end else begin
            w_wr_en = 1'b1;
            if (r_k == IDX_W'(N_COEF - 1)) begin
              w_state_nxt = ST_DRAIN;
            end else begin
              w_k_nxt = r_k + IDX_W'(1);
            end
          end
        end
      end
      ST_DRAIN: begin
        if (w_b_fire) begin
          if (r_row == ROW_W'(LANES - 1)) begin
            w_row_nxt   = '0;
            w_k_nxt     = '0;
            w_clr       = 1'b1;
            w_state_nxt = r_pend_eos ? ST_EOS_OUT : ST_FILL;
          end else begin
            w_row_nxt = r_row + ROW_W'(1);
          end
        end
      end
      ST_EOS_OUT: begin
        if (w_b_fire) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // Row readout for the row that will be presented next; unwritten slots read 0.
  always_comb begin
    w_row_data = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      w_row_data[j] = r_written[{w_row_nxt, ROW_W'(j)}] ? r_buf[{w_row_nxt, ROW_W'(j)}] : '0;
    end
  end

  // FSM state, counters and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_k        <= '0;
      r_row      <= '0;
      r_pend_eos <= 1'b0;
      r_a_b      <= 1'b1;
      r_b_v      <= '0;
      r_b_e      <= '0;
      r_b_d      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_row      <= w_row_nxt;
      r_pend_eos <= w_pend_nxt;
      r_a_b      <= (w_state_nxt != ST_FILL);
      r_b_v      <= {LANES{w_state_nxt != ST_FILL}};
      r_b_e      <= {LANES{w_state_nxt == ST_EOS_OUT}};
      r_b_d      <= (w_state_nxt == ST_DRAIN) ? w_row_data : '0;
    end
  end

  // Written mask: marks filled raster slots, cleared once the block has drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_written <= '0;
    end else if (w_clr) begin
      r_written <= '0;
    end else if (w_wr_en) begin
      r_written[w_pos] <= 1'b1;
    end
  end

  // Coefficient storage; stale contents are masked by the written bits.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_buf[w_pos] <= a.d[0];
    end
  end

endmodule

// File: tb/tb_jpeg_dezigzag_rows.sv
// Bench for jpeg_dezigzag_rows: random and directed blocks compared against a
// zig-zag model derived from the anti-diagonal walk of an 8x8 block.
module tb_jpeg_dezigzag_rows;
  import jpeg_pkg::*;

  typedef struct {
    logic [7:0]   e;
    logic [127:0] d;
    int           cyc;
  } tok_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jpeg_dezigzag_rows_if #(.LANES(1)) a_if ();
  jpeg_dezigzag_rows_if #(.LANES(8)) b_if ();

  jpeg_dezigzag_rows dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_if),
    .b     (b_if)
  );

  tok_t        got_q[$];
  tok_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          zz_tb [64];
  logic [15:0] blk [64];
  logic        bp_rand_en = 1'b0;
  logic [7:0]  bp_force = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every row/EOS token that transfers on the output side.
  always @(negedge clk) begin
    if (rst_n && b_if.v == 8'hff && b_if.b == 8'h00)
      got_q.push_back(tok_t'{b_if.e, 128'(b_if.d), cyc});
  end

  // Output back-pressure: random when enabled, otherwise the directed value.
  always @(posedge clk) begin
    #2;
    if (bp_rand_en)
      b_if.b = ($urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
    else
      b_if.b = bp_force;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_tok(input logic [15:0] d, input logic e);
    bit done;
    done = 1'b0;
    a_if.d[0] = d;
    a_if.e[0] = e;
    a_if.v[0] = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      done = (a_if.b[0] == 1'b0);
      @(posedge clk);
      #1;
    end
    a_if.v[0] = 1'b0;
    a_if.e[0] = 1'b0;
    a_if.d[0] = 16'h0000;
    if (!done) chk("send_timeout", 128'(0), 128'(1));
  endtask

  // Push expected rows for the first n entries of blk (plus EOS), then send them.
  task automatic send_block(input int n, input bit eos, input int gapmax);
    logic [15:0] raster [64];
    tok_t t;
    for (int p = 0; p < 64; p++) raster[p] = 16'h0000;
    for (int k = 0; k < n; k++) raster[zz_tb[k]] = blk[k];
    if (n > 0) begin
      for (int r = 0; r < 8; r++) begin
        t.d = '0;
        t.e = 8'h00;
        t.cyc = 0;
        for (int j = 0; j < 8; j++) t.d[j*16 +: 16] = raster[r*8 + j];
        exp_q.push_back(t);
      end
    end
    if (eos) begin
      t.d = '0;
      t.e = 8'hff;
      t.cyc = 0;
      exp_q.push_back(t);
    end
    for (int k = 0; k < n; k++) begin
      send_tok(blk[k], 1'b0);
      if (gapmax > 0 && (k != n - 1 || eos)) begin
        int g;
        g = $urandom_range(0, gapmax);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (eos) send_tok(16'h0000, 1'b1);
  endtask

  task automatic compare_all(input string tag);
    tok_t g, x;
    for (int n = 0; n < 3000 && got_q.size() < exp_q.size(); n++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_d"}, g.d, x.d);
      chk({tag, "_e"}, 128'(g.e), 128'(x.e));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int idx;
    int t0;
    logic [127:0] snap;
    logic [127:0] row0_ref;
    logic [127:0] row7_ref;

    // Zig-zag order: walk anti-diagonals, alternating direction.
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_tb[idx] = r * 8 + (s - r);
          idx++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz_tb[idx] = r * 8 + (s - r);
          idx++;
        end
      end
    end
    row0_ref = {16'd28, 16'd27, 16'd15, 16'd14, 16'd6, 16'd5, 16'd1, 16'd0};
    row7_ref = {16'd63, 16'd62, 16'd58, 16'd57, 16'd49, 16'd48, 16'd36, 16'd35};

    a_if.v[0] = 1'b0;
    a_if.e[0] = 1'b0;
    a_if.d[0] = 16'h0000;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ab", 128'(a_if.b[0]), 128'(1));
    chk("rst_v", 128'(b_if.v), 128'(0));
    chk("rst_e", 128'(b_if.e), 128'(0));
    chk("rst_d", 128'(b_if.d), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_ab", 128'(a_if.b[0]), 128'(0));

    // Ramp block: latency, row timing and known rows
    for (int k = 0; k < 64; k++) blk[k] = 16'(k);
    send_block(64, 1'b0, 0);
    t0 = cyc;
    chk("ramp_ab_high", 128'(a_if.b[0]), 128'(1));
    chk("ramp_row0_valid", 128'(b_if.v), 128'(8'hff));
    repeat (8) @(posedge clk);
    #1;
    chk("ramp_nrows", 128'(got_q.size()), 128'(8));
    chk("ramp_row0_cyc", 128'(got_q[0].cyc), 128'(t0));
    chk("ramp_row7_cyc", 128'(got_q[7].cyc), 128'(t0 + 7));
    chk("ramp_row0_vals", got_q[0].d, row0_ref);
    chk("ramp_row7_vals", got_q[7].d, row7_ref);
    chk("ramp_ab_low", 128'(a_if.b[0]), 128'(0));
    compare_all("ramp");

    // Back-pressure on lane 3 during row 2
    for (int k = 0; k < 64; k++) blk[k] = 16'($urandom);
    send_block(64, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    snap = 128'(b_if.d);
    chk("bp_row2", snap, exp_q[2].d);
    bp_force = 8'h08;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_d", 128'(b_if.d), snap);
      chk("bp_hold_v", 128'(b_if.v), 128'(8'hff));
      chk("bp_hold_ab", 128'(a_if.b[0]), 128'(1));
    end
    bp_force = 8'h00;
    compare_all("bp");

    // Partial block then EOS
    for (int k = 0; k < 64; k++) blk[k] = 16'h7fff;
    send_block(10, 1'b1, 0);
    for (int n = 0; n < 500 && got_q.size() < 9; n++) @(posedge clk);
    #1;
    chk("partial_ab_low", 128'(a_if.b[0]), 128'(0));
    compare_all("partial");

    // Two full blocks then EOS, random gaps and back-pressure
    bp_rand_en = 1'b1;
    for (int k = 0; k < 64; k++) blk[k] = 16'($urandom);
    send_block(64, 1'b0, 2);
    for (int k = 0; k < 64; k++) blk[k] = 16'($urandom);
    send_block(64, 1'b1, 2);
    compare_all("two_blk");
    bp_rand_en = 1'b0;

    // Ramp with random input gaps
    for (int k = 0; k < 64; k++) blk[k] = 16'(k);
    send_block(64, 1'b0, 3);
    compare_all("gap");

    // Reset while row 4 is presented
    for (int k = 0; k < 64; k++) blk[k] = 16'($urandom);
    send_block(64, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_v", 128'(b_if.v), 128'(0));
    chk("midrst_ab", 128'(a_if.b[0]), 128'(1));
    chk("midrst_e", 128'(b_if.e), 128'(0));
    chk("midrst_d", 128'(b_if.d), 128'(0));
    chk("midrst_rows", 128'(got_q.size()), 128'(4));
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("midrst_row_d", got_q[i].d, exp_q[i].d);
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_release_ab", 128'(a_if.b[0]), 128'(0));
    for (int k = 0; k < 64; k++) blk[k] = 16'(k);
    send_block(64, 1'b0, 0);
    compare_all("post_rst");

    // EOS on an empty stream
    send_block(0, 1'b1, 0);
    compare_all("eos_only");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
